line_refresh_ctrl: RTL and testbench

- Consumer of per-line staleness notifications. The producer is the stale tracker, extended with index/way qualifiers on its event.
- Keeps a pending-refresh bitmap, one bit per (set, way).
- Scans the bitmap round-robin by set and issues one refresh request at a time to the data-array refresh port over a req/ack handshake.
- On completion, pulses refresh_done with the line address. This feeds back as the tracker's counter-clear (access) input, closing the loop between stale detection and selective line refresh.

---
 rtl/refresh_pkg.sv | 18 +
 rtl/line_refresh_ctrl_way_pick.sv | 22 ++
 rtl/line_refresh_ctrl.sv | 125 ++++++++++++
 tb/tb_line_refresh_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// Shared FSM encoding and bitmap addressing helper for the line refresh controller.
package refresh_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } refresh_state_e;

  // Lines of one set occupy consecutive bitmap positions, so a set is a NUM_WAYS-wide slice.
  function automatic int flat_idx(input int index, input int way, input int num_ways);
    return index * num_ways + way;
  endfunction

endpackage

// File: rtl/line_refresh_ctrl_way_pick.sv
// Lowest-numbered pending way within one set's slice of the bitmap.
module way_pick
  import refresh_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic [NUM_WAYS-1:0] pend_bits,
  output logic                any,
  output logic [WAY_BITS-1:0] way
);

  always_comb begin
    any = |pend_bits;
    way = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (pend_bits[i]) way = WAY_BITS'(i);
    end
  end

endmodule

// File: rtl/line_refresh_ctrl.sv
// Pending-refresh bitmap fed by stale notifications, drained one line at a time
// through a req/ack refresh port with a round-robin set scan.
module line_refresh_ctrl
  import refresh_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int INDEX_BITS = $clog2(NUM_SETS),
  parameter int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int CNT_BITS   = $clog2(NUM_SETS * NUM_WAYS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  stale_valid,
  input  logic [INDEX_BITS-1:0] stale_index,
  input  logic [WAY_BITS-1:0]   stale_way,
  input  logic                  access_en,
  input  logic [INDEX_BITS-1:0] access_index,
  input  logic [WAY_BITS-1:0]   access_way,
  output logic                  refresh_req,
  output logic [INDEX_BITS-1:0] refresh_index,
  output logic [WAY_BITS-1:0]   refresh_way,
  input  logic                  refresh_ack,
  output logic                  refresh_done,
  output logic [INDEX_BITS-1:0] done_index,
  output logic [WAY_BITS-1:0]   done_way,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   pending_count
);

  localparam int NUM_LINES = NUM_SETS * NUM_WAYS;
  localparam int LINE_BITS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  refresh_state_e        state_reg;
  logic [NUM_LINES-1:0]  bitmap_reg;
  logic [NUM_LINES-1:0]  bitmap_next;
  logic [INDEX_BITS-1:0] scan_ptr_reg;
  logic [NUM_WAYS-1:0]   set_bits;
  logic                  set_any;
  logic [WAY_BITS-1:0]   set_way;
  logic                  bitmap_nz;

  assign bitmap_nz = |bitmap_reg;
  assign busy      = (state_reg != IDLE);
  assign set_bits  = bitmap_reg[LINE_BITS'(flat_idx(int'(scan_ptr_reg), 0, NUM_WAYS)) +: NUM_WAYS];

  way_pick #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_way_pick (
    .pend_bits (set_bits),
    .any       (set_any),
    .way       (set_way)
  );

  // Later writes win: a fresh stale mark survives any clear in the same cycle.
  always_comb begin
    bitmap_next = bitmap_reg;
    if (state_reg == REQ && refresh_ack)
      bitmap_next[LINE_BITS'(flat_idx(int'(refresh_index), int'(refresh_way), NUM_WAYS))] = 1'b0;
    if (access_en)
      bitmap_next[LINE_BITS'(flat_idx(int'(access_index), int'(access_way), NUM_WAYS))] = 1'b0;
    if (stale_valid)
      bitmap_next[LINE_BITS'(flat_idx(int'(stale_index), int'(stale_way), NUM_WAYS))] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_reg    <= '0;
      pending_count <= '0;
    end else begin
      bitmap_reg    <= bitmap_next;
      pending_count <= CNT_BITS'($countones(bitmap_next));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      scan_ptr_reg  <= '0;
      refresh_req   <= 1'b0;
      refresh_index <= '0;
      refresh_way   <= '0;
      refresh_done  <= 1'b0;
      done_index    <= '0;
      done_way      <= '0;
    end else begin
      refresh_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bitmap_nz && enable) state_reg <= SCAN;
        end
        SCAN: begin
          if (!bitmap_nz || !enable) begin
            state_reg <= IDLE;
          end else if (set_any) begin
            refresh_index <= scan_ptr_reg;
            refresh_way   <= set_way;
            refresh_req   <= 1'b1;
            state_reg     <= REQ;
          end else begin
            scan_ptr_reg <= scan_ptr_reg + 1'b1;
          end
        end
        REQ: begin
          // Once issued, a request is only retired by ack; enable is ignored here.
          if (refresh_ack) begin
            refresh_req  <= 1'b0;
            refresh_done <= 1'b1;
            done_index   <= refresh_index;
            done_way     <= refresh_way;
            scan_ptr_reg <= scan_ptr_reg + 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          state_reg <= (bitmap_nz && enable) ? SCAN : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_refresh_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a set/way array model.
module tb_line_refresh_ctrl;

  localparam int NS = 64;
  localparam int NW = 4;
  localparam int P_IDLE = 0, P_SCAN = 1, P_REQ = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       stale_valid = 1'b0;
  logic [5:0] stale_index = '0;
  logic [1:0] stale_way = '0;
  logic       access_en = 1'b0;
  logic [5:0] access_index = '0;
  logic [1:0] access_way = '0;
  logic       refresh_ack = 1'b0;
  logic       refresh_req;
  logic [5:0] refresh_index;
  logic [1:0] refresh_way;
  logic       refresh_done;
  logic [5:0] done_index;
  logic [1:0] done_way;
  logic       busy;
  logic [8:0] pending_count;

  int errors = 0;
  int checks = 0;

  line_refresh_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .stale_valid   (stale_valid),
    .stale_index   (stale_index),
    .stale_way     (stale_way),
    .access_en     (access_en),
    .access_index  (access_index),
    .access_way    (access_way),
    .refresh_req   (refresh_req),
    .refresh_index (refresh_index),
    .refresh_way   (refresh_way),
    .refresh_ack   (refresh_ack),
    .refresh_done  (refresh_done),
    .done_index    (done_index),
    .done_way      (done_way),
    .busy          (busy),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending lines as a set x way array, one outstanding request.
  bit m_pend [NS][NW];
  int m_phase, m_ptr, m_req_idx, m_req_way, m_done_idx, m_done_way;

  function automatic int m_count();
    int n = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        n += int'(m_pend[s][w]);
    return n;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        m_pend[s][w] = 1'b0;
    m_phase = P_IDLE; m_ptr = 0;
    m_req_idx = 0; m_req_way = 0; m_done_idx = 0; m_done_way = 0;
  endtask

  task automatic model_step();
    bit nxt [NS][NW];
    bit any_old;
    int w;
    nxt = m_pend;
    any_old = (m_count() != 0);
    if (m_phase == P_REQ && refresh_ack) nxt[m_req_idx][m_req_way] = 1'b0;
    if (access_en) nxt[access_index][access_way] = 1'b0;
    if (stale_valid) nxt[stale_index][stale_way] = 1'b1;
    case (m_phase)
      P_IDLE: if (any_old && enable) m_phase = P_SCAN;
      P_SCAN: begin
        if (!any_old || !enable) m_phase = P_IDLE;
        else begin
          w = -1;
          for (int i = NW - 1; i >= 0; i--) if (m_pend[m_ptr][i]) w = i;
          if (w >= 0) begin
            m_req_idx = m_ptr; m_req_way = w; m_phase = P_REQ;
          end else m_ptr = (m_ptr + 1) % NS;
        end
      end
      P_REQ: if (refresh_ack) begin
        m_done_idx = m_req_idx; m_done_way = m_req_way;
        m_ptr = (m_ptr + 1) % NS; m_phase = P_DONE;
      end
      default: m_phase = (any_old && enable) ? P_SCAN : P_IDLE;
    endcase
    m_pend = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_req", refresh_req, m_phase == P_REQ);
      chk("m_ridx", refresh_index, m_req_idx);
      chk("m_rway", refresh_way, m_req_way);
      chk("m_done", refresh_done, m_phase == P_DONE);
      chk("m_didx", done_index, m_done_idx);
      chk("m_dway", done_way, m_done_way);
      chk("m_busy", busy, m_phase != P_IDLE);
      chk("m_cnt", pending_count, m_count());
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; stale_valid = 1'b0; access_en = 1'b0; refresh_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic mark(input int s, input int w);
    stale_valid = 1'b1; stale_index = 6'(s); stale_way = 2'(w);
    @(negedge clk);
    stale_valid = 1'b0;
  endtask

  task automatic wait_req(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (refresh_req) ok = 1'b1;
      else @(negedge clk);
    end
    chk("wait_req_timeout", ok, 1);
  endtask

  task automatic do_ack();
    refresh_ack = 1'b1;
    @(negedge clk);
    refresh_ack = 1'b0;
  endtask

  initial begin
    int exp_idx [3] = '{2, 5, 5};
    int exp_way [3] = '{0, 1, 3};
    int exp_cnt [3] = '{2, 1, 0};
    int nreq;

    // Reset values and basic latency
    do_reset();
    chk("t1_rst_req", refresh_req, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_cnt", pending_count, 0);
    chk("t1_rst_done", refresh_done, 0);
    enable = 1'b1;
    mark(0, 2);
    chk("t1_cnt_k1", pending_count, 1);
    chk("t1_busy_k1", busy, 0);
    @(negedge clk);
    chk("t1_busy_k2", busy, 1);
    chk("t1_req_k2", refresh_req, 0);
    @(negedge clk);
    chk("t1_req_k3", refresh_req, 1);
    chk("t1_ridx", refresh_index, 0);
    chk("t1_rway", refresh_way, 2);
    do_ack();
    chk("t1_done", refresh_done, 1);
    chk("t1_didx", done_index, 0);
    chk("t1_dway", done_way, 2);
    chk("t1_cnt0", pending_count, 0);
    chk("t1_req_off", refresh_req, 0);
    @(negedge clk);
    chk("t1_done_pulse", refresh_done, 0);
    chk("t1_busy_fall", busy, 0);

    // Round-robin order across sets, lowest way first
    do_reset();
    mark(5, 1); mark(5, 3); mark(2, 0);
    enable = 1'b1;
    chk("t2_cnt3", pending_count, 3);
    for (int j = 0; j < 3; j++) begin
      wait_req(200);
      chk("t2_ridx", refresh_index, exp_idx[j]);
      chk("t2_rway", refresh_way, exp_way[j]);
      do_ack();
      chk("t2_done", refresh_done, 1);
      chk("t2_cnt", pending_count, exp_cnt[j]);
    end

    // Pointer wrap from the last set back to set 0
    do_reset();
    enable = 1'b1;
    mark(63, 0);
    repeat (40) @(negedge clk);
    mark(1, 0);
    wait_req(200);
    chk("t3_first_idx", refresh_index, 63);
    do_ack();
    wait_req(200);
    chk("t3_second_idx", refresh_index, 1);
    chk("t3_second_way", refresh_way, 0);
    do_ack();

    // Stale wins over same-cycle access; access to in-flight line does not cancel it
    do_reset();
    enable = 1'b1;
    stale_valid = 1'b1; stale_index = 6'd7; stale_way = 2'd1;
    access_en = 1'b1; access_index = 6'd7; access_way = 2'd1;
    @(negedge clk);
    stale_valid = 1'b0; access_en = 1'b0;
    chk("t4_cnt_set", pending_count, 1);
    wait_req(200);
    chk("t4_ridx", refresh_index, 7);
    chk("t4_rway", refresh_way, 1);
    access_en = 1'b1;
    @(negedge clk);
    access_en = 1'b0;
    chk("t4_cnt_clr", pending_count, 0);
    chk("t4_req_held", refresh_req, 1);
    do_ack();
    chk("t4_done", refresh_done, 1);
    chk("t4_didx", done_index, 7);
    nreq = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      nreq += int'(refresh_req);
    end
    chk("t4_no_rereq", nreq, 0);
    chk("t4_idle", busy, 0);

    // enable gating, and enable drop while a request is outstanding
    do_reset();
    mark(10, 0); mark(10, 1); mark(20, 2); mark(30, 3);
    repeat (10) @(negedge clk);
    chk("t5_no_req", refresh_req, 0);
    chk("t5_cnt4", pending_count, 4);
    chk("t5_idle", busy, 0);
    enable = 1'b1;
    wait_req(200);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_req_held", refresh_req, 1);
    chk("t5_ridx", refresh_index, 10);
    chk("t5_rway", refresh_way, 0);
    do_ack();
    chk("t5_done", refresh_done, 1);
    chk("t5_cnt3", pending_count, 3);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nreq += int'(refresh_req);
    end
    chk("t5_gated", nreq, 0);
    chk("t5_busy_low", busy, 0);

    // Asynchronous reset in the middle of a handshake
    do_reset();
    enable = 1'b1;
    mark(3, 0); mark(3, 1);
    wait_req(200);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_drop", refresh_req, 0);
    chk("t6_cnt0", pending_count, 0);
    chk("t6_busy0", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done_rst", refresh_done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", refresh_done, 0);
      chk("t6_no_req", refresh_req, 0);
    end

    // Randomized traffic, checked by the model every cycle
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      stale_valid = ($urandom_range(0, 3) == 0);
      stale_index = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, NS - 1));
      stale_way   = 2'($urandom_range(0, NW - 1));
      access_en   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: begin access_index = refresh_index; access_way = refresh_way; end
        1: begin access_index = stale_index; access_way = stale_way; end
        default: begin
          access_index = 6'($urandom_range(0, 7));
          access_way   = 2'($urandom_range(0, NW - 1));
        end
      endcase
      refresh_ack = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    stale_valid = 1'b0; access_en = 1'b0; refresh_ack = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
